dmem_if: RTL and testbench
==========================

# dmem_if

Data-memory interface directly downstream of the memory-access stage. It consumes that stage's registered load/store request and drives a single-outstanding, XLEN-wide valid/ack data bus, performing alignment checking, byte-lane steering, timeout detection and load-data right-alignment. It returns `mem_rdata`/`mem_ready`/`mem_error` to the memory-access stage, which holds its request stable while `mem_ready` and `mem_error` are both low.

## Interface
- `XLEN`, 64: data/address width, 32 or 64.
- `TIMEOUT`, 255: maximum bus wait cycles before a fault, 1..255.

- `clk` in 1: clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `mem_addr` in XLEN: byte address.
- `mem_wdata` in XLEN: store data, right-aligned.
- `mem_read_req` in 1: load request, level, held until ready/error.
- `mem_write_req` in 1: store request, level, held until ready/error.
- `mem_size` in 3: 0=byte, 1=half, 2=word, 3=double.
- `mem_signed` in 1: sign-extend load result.
- `mem_rdata` out XLEN: load result, right-aligned and extended.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_error` out 1: one-cycle fault pulse.
- `bus_req` out 1: bus request, held until `bus_ack`.
- `bus_we` out 1: 1=write.
- `bus_addr` out XLEN: `mem_addr` with the low log2(XLEN/8) bits cleared.
- `bus_wdata` out XLEN: lane-shifted store data.
- `bus_wstrb` out XLEN/8: byte enables.
- `bus_rdata` in XLEN: read data, valid with `bus_ack`.
- `bus_ack` in 1: transfer complete.
- `bus_err` in 1: transfer fault, sampled only with `bus_ack`.

## Operation
- FSM states: IDLE, BUS, DONE, FAULT. Reset state is IDLE.
- IDLE, no request: stay in IDLE.
- IDLE, request present: the request is validated combinationally.
  - Both read and write asserted: FAULT.
  - `mem_size` > 3, or size 3 with XLEN=32: FAULT.
  - Address not a multiple of 2^size: FAULT.
  - Otherwise: latch address, offset, size, signed and direction, then go to BUS.
- BUS: `bus_req`=1; wait counter increments each cycle.
  - `bus_ack` && `bus_err`: FAULT.
  - `bus_ack` only: capture read data, go to DONE.
  - Counter reaches `TIMEOUT` without ack: drop `bus_req`, go to FAULT.
- DONE: `mem_ready`=1 for one cycle, then IDLE.
- FAULT: `mem_error`=1 for one cycle, then IDLE. No bus cycle is issued for validation faults.
- Lane rules, with off = addr low bits:
  - `bus_wdata` = `mem_wdata` << 8·off.
  - `bus_wstrb` = ((1 << 2^size) − 1) << off.
  - Reads: `bus_rdata` >> 8·off, truncated to 8·2^size bits, then sign-extended if `mem_signed`, else zero-extended.
  - Writes: `mem_rdata`=0.
- Back-to-back identical requests are separate accesses. After each DONE/FAULT the block returns to IDLE and re-samples the request inputs.

## Timing
- Reset value of every output is 0. Outputs are registered.
- Validation fault: request seen at cycle 0, `mem_error` at cycle 1.
- Normal access: `bus_req` from cycle 1. Ack at cycle k gives `mem_ready` and valid `mem_rdata` at cycle k+1.
- Zero-wait bus (ack in cycle 1): `mem_ready` in cycle 2, so minimum latency is 2.
- `bus_req`, `bus_we`, `bus_addr`, `bus_wdata` and `bus_wstrb` are stable from assertion of `bus_req` until the ack cycle inclusive. `bus_req` is low in the cycle after ack.
- Timeout: `bus_req` is high for exactly `TIMEOUT` cycles; `mem_error` follows on the next cycle.
- `bus_ack` while `bus_req`=0 is ignored.
- Request inputs changing while in BUS are ignored; latched values are used.
- Reset asserted mid-transaction: `bus_req`, `mem_ready` and `mem_error` clear immediately and asynchronously. The FSM returns to IDLE and the counter clears.
- `mem_rdata` holds its value outside the DONE cycle.

## Structure
- The shared pipeline package holds:
  - `mem_size_e` (MEM_B, MEM_H, MEM_W, MEM_D)
  - `dmem_state_e`
  - load-access-fault and store-access-fault cause constants
- One combinational sub-module, `dmem_lane_align`, covers write shift/strobe generation and read shift/extension, parameterized by XLEN.
- The FSM and timeout counter sit in `dmem_if`.

## Test plan
All scenarios use XLEN=64.
- **Signed byte load:** LB, signed, addr 0x1003, ack in cycle 1 with `bus_rdata`=0x0000_0000_8000_0000 -> `bus_addr`=0x1000, `bus_wstrb`=0x08; cycle 2 `mem_ready`=1, `mem_rdata`=0xFFFF_FFFF_FFFF_FF80. Repeat unsigned -> 0x80.
- **Half store:** SH addr 0x2006, `mem_wdata`=0xBEEF, ack after 3 wait cycles -> `bus_we`=1, `bus_addr`=0x2000, `bus_wstrb`=0xC0, `bus_wdata`=0xBEEF_0000_0000_0000; `mem_ready` exactly one cycle after ack.
- **Misaligned load:** LW addr 0x1002 -> `mem_error` at cycle 1, `bus_req` never asserted. Same result for read+write asserted together.
- **Timeout:** `TIMEOUT`=4, no ack -> `bus_req` high cycles 1-4, `mem_error` at cycle 5, IDLE at cycle 6.
- **Bus error:** LD addr 0x3000, `bus_ack`=`bus_err`=1 -> `mem_error` pulse, `mem_ready` stays 0.
- **Reset mid-access:** deassert `resetn` while in BUS -> `bus_req` 0 without a clock edge. After release with the request still present, a fresh access starts, with `bus_req` one cycle later.

Source files
------------

// File: rtl/dmem_if_pkg.sv
// Shared pipeline types and constants for the data-memory interface.
package dmem_if_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } dmem_state_e;

  localparam int unsigned CNT_W = 8;

  localparam logic [4:0] CAUSE_LOAD_ACCESS_FAULT  = 5'd5;
  localparam logic [4:0] CAUSE_STORE_ACCESS_FAULT = 5'd7;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(mem_size_e size);
    logic [2:0] m;
    case (size)
      MEM_B:   m = 3'b000;
      MEM_H:   m = 3'b001;
      MEM_W:   m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store shift/strobe generation and load right-align/extension.
module dmem_lane_align
  import dmem_if_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  localparam int unsigned STRB_W = XLEN / 8,
  localparam int unsigned OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]   wr_data_i,
  input  logic [OFF_W-1:0]  wr_off_i,
  input  mem_size_e         wr_size_i,
  input  logic [XLEN-1:0]   rd_data_i,
  input  logic [OFF_W-1:0]  rd_off_i,
  input  mem_size_e         rd_size_i,
  input  logic              rd_signed_i,
  output logic [XLEN-1:0]   wr_data_c,
  output logic [STRB_W-1:0] wr_strb_c,
  output logic [XLEN-1:0]   rd_data_c
);

  logic [3:0]      wr_nbytes;
  logic [6:0]      rd_nbits;
  logic [XLEN-1:0] rd_shift;
  logic [XLEN-1:0] rd_mask;
  logic [XLEN-1:0] rd_msb;
  logic            rd_sign;

  always_comb begin
    wr_nbytes = 4'd1 << wr_size_i;
    wr_data_c = wr_data_i << {wr_off_i, 3'b000};
    wr_strb_c = (~({STRB_W{1'b1}} << wr_nbytes)) << wr_off_i;
  end

  // The mask covers the access width; its top set bit selects the sign bit.
  always_comb begin
    rd_nbits  = 7'd8 << rd_size_i;
    rd_shift  = rd_data_i >> {rd_off_i, 3'b000};
    rd_mask   = ~({XLEN{1'b1}} << rd_nbits);
    rd_msb    = rd_mask & ~(rd_mask >> 1);
    rd_sign   = rd_signed_i & (|(rd_shift & rd_msb));
    rd_data_c = (rd_shift & rd_mask) | ({XLEN{rd_sign}} & ~rd_mask);
  end

endmodule

// File: rtl/dmem_if.sv
// Single-outstanding data-memory bus master: request validation, bus handshake
// with timeout, and load-data return to the memory-access stage.
module dmem_if
  import dmem_if_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_read_req,
  input  logic              mem_write_req,
  input  logic [2:0]        mem_size,
  input  logic              mem_signed,
  output logic [XLEN-1:0]   mem_rdata,
  output logic              mem_ready,
  output logic              mem_error,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_wstrb,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_ack,
  input  logic              bus_err
);

  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
  logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
  logic [STRB_W-1:0] bus_wstrb_q, bus_wstrb_d;
  logic [OFF_W-1:0]  off_q, off_d;
  mem_size_e         size_q, size_d;
  logic              signed_q, signed_d;
  logic              mem_ready_q, mem_ready_d;
  logic              mem_error_q, mem_error_d;
  logic [XLEN-1:0]   mem_rdata_q, mem_rdata_d;

  mem_size_e         req_size_c;
  logic              req_any_c;
  logic              req_bad_c;
  logic [XLEN-1:0]   lane_wdata_c;
  logic [STRB_W-1:0] lane_wstrb_c;
  logic [XLEN-1:0]   lane_rdata_c;

  dmem_lane_align #(.XLEN(XLEN)) u_lane (
    .wr_data_i   (mem_wdata),
    .wr_off_i    (mem_addr[OFF_W-1:0]),
    .wr_size_i   (req_size_c),
    .rd_data_i   (bus_rdata),
    .rd_off_i    (off_q),
    .rd_size_i   (size_q),
    .rd_signed_i (signed_q),
    .wr_data_c   (lane_wdata_c),
    .wr_strb_c   (lane_wstrb_c),
    .rd_data_c   (lane_rdata_c)
  );

  // Request validation: conflicting direction, unsupported size, misalignment.
  always_comb begin
    req_size_c = mem_size_e'(mem_size[1:0]);
    req_any_c  = mem_read_req | mem_write_req;
    req_bad_c  = (mem_read_req & mem_write_req)
               | mem_size[2]
               | ((XLEN == 32) && (mem_size == 3'd3))
               | (|(mem_addr[2:0] & align_mask(req_size_c)));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    off_d       = off_q;
    size_d      = size_q;
    signed_d    = signed_q;
    mem_rdata_d = mem_rdata_q;
    mem_ready_d = 1'b0;
    mem_error_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_any_c) begin
          if (req_bad_c) begin
            state_d     = FAULT;
            mem_error_d = 1'b1;
          end else begin
            state_d     = BUS;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write_req;
            bus_addr_d  = {mem_addr[XLEN-1:OFF_W], OFF_W'(0)};
            bus_wdata_d = lane_wdata_c;
            bus_wstrb_d = lane_wstrb_c;
            off_d       = mem_addr[OFF_W-1:0];
            size_d      = req_size_c;
            signed_d    = mem_signed;
          end
        end
      end

      BUS: begin
        // An ack on the final permitted wait cycle still wins over the timeout.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (bus_err) begin
            state_d     = FAULT;
            mem_error_d = 1'b1;
          end else begin
            state_d     = DONE;
            mem_ready_d = 1'b1;
            mem_rdata_d = bus_we_q ? '0 : lane_rdata_c;
          end
        end else if ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT)) begin
          bus_req_d   = 1'b0;
          state_d     = FAULT;
          mem_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      off_q       <= '0;
      size_q      <= MEM_B;
      signed_q    <= 1'b0;
      mem_rdata_q <= '0;
      mem_ready_q <= 1'b0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      off_q       <= off_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      mem_rdata_q <= mem_rdata_d;
      mem_ready_q <= mem_ready_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign mem_rdata = mem_rdata_q;
  assign mem_ready = mem_ready_q;
  assign mem_error = mem_error_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;

endmodule

// File: tb/tb_dmem_if.sv
// Self-checking bench for dmem_if (XLEN=64, TIMEOUT=4): directed plan steps
// followed by randomized accesses checked against a per-access reference model.
module tb_dmem_if;

  localparam int unsigned XLEN = 64;
  localparam int unsigned TO   = 4;

  logic            clk = 1'b0;
  logic            resetn;
  logic [63:0]     mem_addr, mem_wdata, mem_rdata;
  logic            mem_read_req, mem_write_req, mem_signed;
  logic [2:0]      mem_size;
  logic            mem_ready, mem_error;
  logic            bus_req, bus_we, bus_ack, bus_err;
  logic [63:0]     bus_addr, bus_wdata, bus_rdata;
  logic [7:0]      bus_wstrb;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] exp_hold = '0;

  dmem_if #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_size(mem_size), .mem_signed(mem_signed),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_error(mem_error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drop_req();
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;
  endtask

  // One complete access; ack_at is the cycle of bus_ack (beyond TO means none).
  task automatic access(input logic [63:0] addr, input logic [63:0] wdata,
                        input logic rd, input logic wr, input logic [2:0] size,
                        input logic sgn, input int ack_at, input logic [63:0] rdata,
                        input logic err, input logic scr);
    logic        bad, acked;
    int          off, nb, last;
    logic [63:0] e_addr, e_wdata, sh, mask, val;
    logic [7:0]  e_strb;
    bad = (rd && wr) || (size > 3'd3) || ((addr % (64'd1 << size)) != 64'd0);
    off = int'(addr[2:0]);
    @(negedge clk);
    mem_addr = addr; mem_wdata = wdata; mem_size = size; mem_signed = sgn;
    mem_read_req = rd; mem_write_req = wr;
    if (bad) begin
      @(posedge clk); #1;
      chk("vfault_err", 64'(mem_error), 64'd1);
      chk("vfault_rdy", 64'(mem_ready), 64'd0);
      chk("vfault_req", 64'(bus_req), 64'd0);
      chk("vfault_hold", mem_rdata, exp_hold);
      drop_req();
      @(posedge clk); #1;
      chk("vfault_req2", 64'(bus_req), 64'd0);
      chk("vfault_err2", 64'(mem_error), 64'd0);
      return;
    end
    nb      = 8 << size;
    e_addr  = {addr[63:3], 3'b000};
    e_wdata = wdata << (8 * off);
    e_strb  = 8'(((1 << (1 << size)) - 1) << off);
    acked   = (ack_at >= 1) && (ack_at <= int'(TO));
    last    = acked ? ack_at : int'(TO);
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = {$urandom, $urandom};
      chk("bus_req", 64'(bus_req), 64'd1);
      chk("bus_we", 64'(bus_we), 64'(wr));
      chk("bus_addr", bus_addr, e_addr);
      chk("bus_wstrb", 64'(bus_wstrb), 64'(e_strb));
      chk("bus_wdata", bus_wdata, e_wdata);
      chk("busy_rdy", 64'({mem_ready, mem_error}), 64'd0);
      chk("busy_hold", mem_rdata, exp_hold);
      if (scr) begin
        mem_addr = {$urandom, $urandom}; mem_wdata = {$urandom, $urandom};
        mem_size = 3'($urandom_range(0, 7)); mem_signed = ~sgn;
      end
      if (c == ack_at) begin
        bus_ack = 1'b1; bus_err = err; bus_rdata = rdata;
      end
    end
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_err = 1'b0;
    chk("resp_req", 64'(bus_req), 64'd0);
    if (acked && !err) begin
      if (wr) val = '0;
      else begin
        sh = rdata >> (8 * off);
        if (nb >= 64) val = sh;
        else begin
          mask = (64'd1 << nb) - 64'd1;
          val  = sh & mask;
          if (sgn && val[nb-1]) val = val | ~mask;
        end
      end
      exp_hold = val;
      chk("resp_rdy", 64'(mem_ready), 64'd1);
      chk("resp_err", 64'(mem_error), 64'd0);
    end else begin
      chk("resp_rdy", 64'(mem_ready), 64'd0);
      chk("resp_err", 64'(mem_error), 64'd1);
    end
    chk("resp_rdata", mem_rdata, exp_hold);
    drop_req();
    @(posedge clk); #1;
    chk("idle_pulse", 64'({mem_ready, mem_error, bus_req}), 64'd0);
    chk("idle_hold", mem_rdata, exp_hold);
  endtask

  initial begin
    resetn = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_size = '0; mem_signed = 1'b0;
    mem_read_req = 1'b0; mem_write_req = 1'b0;
    bus_rdata = '0; bus_ack = 1'b0; bus_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", 64'({mem_ready, mem_error, bus_req, bus_we}), 64'd0);
    chk("rst_rdata", mem_rdata, 64'd0);
    chk("rst_addr", bus_addr | bus_wdata | 64'(bus_wstrb), 64'd0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    // Signed / unsigned byte load, zero-wait bus
    access(64'h1003, 64'd0, 1'b1, 1'b0, 3'd0, 1'b1, 1, 64'h0000_0000_8000_0000, 1'b0, 1'b0);
    chk("lb_signed", mem_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    access(64'h1003, 64'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1, 64'h0000_0000_8000_0000, 1'b0, 1'b0);
    chk("lbu", mem_rdata, 64'h80);

    // Half store with three wait cycles
    access(64'h2006, 64'hBEEF, 1'b0, 1'b1, 3'd1, 1'b0, 4, 64'd0, 1'b0, 1'b0);
    chk("sh_rdata", mem_rdata, 64'd0);

    // Validation faults: misaligned, conflicting direction, oversize
    access(64'h1002, 64'd0, 1'b1, 1'b0, 3'd2, 1'b0, 1, 64'd0, 1'b0, 1'b0);
    access(64'h1000, 64'd0, 1'b1, 1'b1, 3'd0, 1'b0, 1, 64'd0, 1'b0, 1'b0);
    access(64'h1000, 64'd0, 1'b1, 1'b0, 3'd4, 1'b0, 1, 64'd0, 1'b0, 1'b0);

    // Timeout, then bus error
    access(64'h3000, 64'd0, 1'b1, 1'b0, 3'd3, 1'b0, 0, 64'd0, 1'b0, 1'b0);
    access(64'h3000, 64'd0, 1'b1, 1'b0, 3'd3, 1'b0, 1, 64'h1234, 1'b1, 1'b0);

    // Stray ack while idle
    @(negedge clk); bus_ack = 1'b1; bus_err = 1'b1;
    @(posedge clk); #1; bus_ack = 1'b0; bus_err = 1'b0;
    chk("stray_ack", 64'({mem_ready, mem_error, bus_req}), 64'd0);
    @(posedge clk); #1;
    chk("stray_ack2", 64'({mem_ready, mem_error, bus_req}), 64'd0);

    // Reset mid-access, request still held afterwards
    @(negedge clk);
    mem_addr = 64'h3000; mem_size = 3'd3; mem_signed = 1'b0; mem_read_req = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_req", 64'(bus_req), 64'd1);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("async_rst", 64'({mem_ready, mem_error, bus_req}), 64'd0);
    exp_hold = '0;
    chk("async_rdata", mem_rdata, exp_hold);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    chk("restart_req", 64'(bus_req), 64'd1);
    bus_ack = 1'b1; bus_rdata = 64'hCAFE_F00D_DEAD_BEEF;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("restart_rdy", 64'(mem_ready), 64'd1);
    chk("restart_rdata", mem_rdata, 64'hCAFE_F00D_DEAD_BEEF);
    exp_hold = 64'hCAFE_F00D_DEAD_BEEF;
    drop_req();
    @(posedge clk); #1;

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      logic [63:0] a;
      logic [2:0]  sz;
      logic        r, w;
      int          dir;
      a   = {$urandom, $urandom};
      sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) a = a & ~((64'd1 << sz[1:0]) - 64'd1);
      dir = $urandom_range(0, 9);
      r   = (dir < 5) || (dir == 9);
      w   = (dir >= 5);
      access(a, {$urandom, $urandom}, r, w, sz, 1'($urandom_range(0, 1)),
             $urandom_range(1, 5), {$urandom, $urandom},
             ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
